inverter_checker: RTL and testbench

INVERTER_CHECKER -- requirements
Module: inverter_checker

---
 rtl/inverter_checker.sv | 143 ++++++++++++++
 tb/tb_inverter_checker.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inverter_checker.sv
// inverter_checker: drives an alternating 0,1,0,1... stimulus into an external
// inverter, waits a fixed settle time per vector, samples its output against
// ~a and reports a saturating mismatch count plus a pass/done summary.
module inverter_checker #(
   parameter int unsigned NUM_VECTORS = 4,
   parameter int unsigned SETTLE      = 2,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             a,
   input  logic             y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] vec_idx
);

   // Settle counter must hold values up to SETTLE.
   localparam int unsigned SCNT_W = $clog2(SETTLE + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_a;
   logic                w_a_nxt;
   logic                r_busy;
   logic                w_busy_nxt;
   logic                r_done;
   logic                w_done_nxt;
   logic                r_pass;
   logic                w_pass_nxt;
   logic [CNT_W-1:0]    r_err;
   logic [CNT_W-1:0]    w_err_nxt;
   logic [CNT_W-1:0]    r_vec;
   logic [CNT_W-1:0]    w_vec_nxt;
   logic [SCNT_W-1:0]   r_scnt;
   logic [SCNT_W-1:0]   w_scnt_nxt;
   logic                w_mismatch;
   logic                w_last_vec;
   logic                w_settled;
   logic                w_err_max;

   // Case-equality so an X or Z on y counts as a mismatch in simulation.
   assign w_mismatch = (y !== ~r_a);
   assign w_last_vec = (r_vec == CNT_W'(NUM_VECTORS - 1));
   assign w_settled  = (r_scnt == SCNT_W'(SETTLE - 1));
   assign w_err_max  = (r_err == {CNT_W{1'b1}});

   // Next-state and next-output logic; every register holds unless changed.
   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_pass_nxt  = r_pass;
      w_err_nxt   = r_err;
      w_vec_nxt   = r_vec;
      w_scnt_nxt  = r_scnt;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_a_nxt     = 1'b0;
               w_vec_nxt   = '0;
               w_err_nxt   = '0;
               w_pass_nxt  = 1'b0;
               w_scnt_nxt  = '0;
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            w_scnt_nxt = r_scnt + SCNT_W'(1);
            if (w_settled) begin
               w_state_nxt = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            if (w_mismatch && !w_err_max) begin
               w_err_nxt = r_err + CNT_W'(1);
            end
            if (w_last_vec) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_vec_nxt   = r_vec + CNT_W'(1);
               w_a_nxt     = ~r_a;
               w_scnt_nxt  = '0;
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_DONE: begin
            w_pass_nxt  = (r_err == '0);
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // busy/done are registered decodes of the state being entered.
      w_busy_nxt = (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_SAMPLE);
      w_done_nxt = (w_state_nxt == ST_DONE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_a     <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_err   <= '0;
         r_vec   <= '0;
         r_scnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_a     <= w_a_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_pass  <= w_pass_nxt;
         r_err   <= w_err_nxt;
         r_vec   <= w_vec_nxt;
         r_scnt  <= w_scnt_nxt;
      end
   end

   assign a         = r_a;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign err_count = r_err;
   assign vec_idx   = r_vec;

endmodule

// File: tb/tb_inverter_checker.sv
// tb_inverter_checker: directed scenarios for inverter_checker with a
// selectable model of the device under test (ideal, stuck-at-0, buffer).
module tb_inverter_checker;

   logic       clk;
   logic       rst;
   logic       start;
   logic       a;
   logic       y;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] err_count;
   logic [7:0] vec_idx;
   int         mode;   // 0 ideal inverter, 1 stuck at 0, 2 buffer

   logic       rst2;
   logic       start2;
   logic       a2;
   logic       y2;
   logic       busy2;
   logic       done2;
   logic       pass2;
   logic [1:0] err2;
   logic [1:0] vec2;

   int checks;
   int failures;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign y  = (mode == 0) ? ~a : ((mode == 1) ? 1'b0 : a);
   assign y2 = a2;

   inverter_checker #(.NUM_VECTORS(4), .SETTLE(2), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .y(y), .busy(busy),
      .done(done), .pass(pass), .err_count(err_count), .vec_idx(vec_idx)
   );

   inverter_checker #(.NUM_VECTORS(4), .SETTLE(2), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst2), .start(start2), .a(a2), .y(y2), .busy(busy2),
      .done(done2), .pass(pass2), .err_count(err2), .vec_idx(vec2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; rst2 = 1'b1; start2 = 1'b0; mode = 0;
      tick(); tick();
      rst = 1'b0; rst2 = 1'b0;
      checks++;
      if ({a, busy, done, pass} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got a/busy/done/pass=%b exp=0000", {a, busy, done, pass});
      end
      checks++;
      if (err_count !== 8'd0 || vec_idx !== 8'd0) begin
         failures++;
         $display("FAIL reset_counts got err=%0d vec=%0d exp 0/0", err_count, vec_idx);
      end
      checks++;
      if ({a2, busy2, done2, pass2, err2, vec2} !== 8'd0) begin
         failures++;
         $display("FAIL reset_sat got %b exp 00000000", {a2, busy2, done2, pass2, err2, vec2});
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_no_start busy got=%b exp=0", busy);
      end
   endtask

   // Ideal inverter: full cycle-by-cycle stimulus and status sequence.
   task automatic test_ideal();
      int  v;
      logic exp_a;
      mode = 0;
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         v = (c - 1) / 3;
         exp_a = (v % 2 == 1);
         checks++;
         if (a !== exp_a || vec_idx !== 8'(v)) begin
            failures++;
            $display("FAIL ideal_vec cyc=%0d got a=%b vec=%0d exp a=%b vec=%0d", c, a, vec_idx, exp_a, v);
         end
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL ideal_busy cyc=%0d got busy=%b done=%b exp 1/0", c, busy, done);
         end
         tick();
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || a !== 1'b1 || err_count !== 8'd0) begin
         failures++;
         $display("FAIL ideal_done cyc=13 got done=%b busy=%b a=%b err=%0d exp 1/0/1/0", done, busy, a, err_count);
      end
      tick();
      checks++;
      if (pass !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL ideal_pass got pass=%b done=%b exp 1/0", pass, done);
      end
   endtask

   // Stuck-at-0 output: the two a=0 vectors fail; results hold in IDLE.
   task automatic test_stuck0();
      mode = 1;
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         checks++;
         if (done !== (c == 13)) begin
            failures++;
            $display("FAIL stuck0_done cyc=%0d got=%b exp=%b", c, done, (c == 13));
         end
         if (c < 13) tick();
      end
      checks++;
      if (err_count !== 8'd2) begin
         failures++;
         $display("FAIL stuck0_err got=%0d exp=2", err_count);
      end
      tick(); tick(); tick(); tick();
      checks++;
      if (pass !== 1'b0 || err_count !== 8'd2 || vec_idx !== 8'd3 || busy !== 1'b0) begin
         failures++;
         $display("FAIL stuck0_hold got pass=%b err=%0d vec=%0d busy=%b exp 0/2/3/0", pass, err_count, vec_idx, busy);
      end
   endtask

   // Buffer in place of inverter: every vector mismatches.
   task automatic test_buffer();
      mode = 2;
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 1; c < 13; c++) tick();
      checks++;
      if (done !== 1'b1 || err_count !== 8'd4) begin
         failures++;
         $display("FAIL buffer_done got done=%b err=%0d exp 1/4", done, err_count);
      end
      tick();
      checks++;
      if (pass !== 1'b0) begin
         failures++;
         $display("FAIL buffer_pass got=%b exp=0", pass);
      end
   endtask

   // Mid-run start ignored; held start yields back-to-back runs.
   task automatic test_back_to_back();
      mode = 0;
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         checks++;
         if (done !== (c == 13) || busy !== (c < 13)) begin
            failures++;
            $display("FAIL b2b_run1 cyc=%0d got done=%b busy=%b exp %b/%b", c, done, busy, (c == 13), (c < 13));
         end
         start = (c == 5) || (c == 13);
         tick();
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b1) begin
         failures++;
         $display("FAIL b2b_idle_gap got busy=%b done=%b pass=%b exp 0/0/1", busy, done, pass);
      end
      tick();
      checks++;
      if (busy !== 1'b1 || a !== 1'b0 || vec_idx !== 8'd0 || pass !== 1'b0) begin
         failures++;
         $display("FAIL b2b_restart got busy=%b a=%b vec=%0d pass=%b exp 1/0/0/0", busy, a, vec_idx, pass);
      end
      for (int c = 15; c <= 27; c++) begin
         checks++;
         if (done !== (c == 27)) begin
            failures++;
            $display("FAIL b2b_run2 cyc=%0d got done=%b exp=%b", c, done, (c == 27));
         end
         if (c == 27) start = 1'b0;
         tick();
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_stop got busy=%b exp=0", busy);
      end
   endtask

   // Reset mid-run aborts without done; reset beats start; fresh run works.
   task automatic test_reset_abort();
      int done_seen;
      mode = 1;
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 1; c < 9; c++) tick();
      checks++;
      if (vec_idx !== 8'd2 || busy !== 1'b1 || err_count !== 8'd1) begin
         failures++;
         $display("FAIL abort_pre got vec=%0d busy=%b err=%0d exp 2/1/1", vec_idx, busy, err_count);
      end
      rst = 1'b1; tick(); rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || a !== 1'b0 || err_count !== 8'd0 || vec_idx !== 8'd0 || done !== 1'b0) begin
         failures++;
         $display("FAIL abort_post got busy=%b a=%b err=%0d vec=%0d done=%b exp all 0", busy, a, err_count, vec_idx, done);
      end
      done_seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (done === 1'b1 || busy === 1'b1) done_seen++;
         tick();
      end
      checks++;
      if (done_seen !== 0) begin
         failures++;
         $display("FAIL abort_no_done got active_cycles=%0d exp=0", done_seen);
      end
      rst = 1'b1; start = 1'b1; tick();
      rst = 1'b0; start = 1'b0; tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_priority got busy=%b exp=0", busy);
      end
      mode = 0;
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 1; c < 13; c++) tick();
      checks++;
      if (done !== 1'b1 || err_count !== 8'd0 || vec_idx !== 8'd3) begin
         failures++;
         $display("FAIL abort_rerun got done=%b err=%0d vec=%0d exp 1/0/3", done, err_count, vec_idx);
      end
      tick();
      checks++;
      if (pass !== 1'b1) begin
         failures++;
         $display("FAIL abort_rerun_pass got=%b exp=1", pass);
      end
   endtask

   // Narrow counter: four mismatches saturate at 3 instead of wrapping.
   task automatic test_saturate();
      start2 = 1'b1; tick(); start2 = 1'b0;
      for (int c = 1; c < 13; c++) tick();
      checks++;
      if (done2 !== 1'b1 || err2 !== 2'd3) begin
         failures++;
         $display("FAIL sat_err got done=%b err=%0d exp 1/3", done2, err2);
      end
      tick();
      checks++;
      if (pass2 !== 1'b0 || err2 !== 2'd3) begin
         failures++;
         $display("FAIL sat_pass got pass=%b err=%0d exp 0/3", pass2, err2);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      start    = 1'b0;
      rst2     = 1'b1;
      start2   = 1'b0;
      mode     = 0;
      test_reset();
      test_ideal();
      test_stuck0();
      test_buffer();
      test_back_to_back();
      test_reset_abort();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
